// File: rtl/memory_responder_pkg.sv
// Shared definitions for the memory responder: FSM state encoding, default widths and
// the upper-address range helper.
package memory_responder_pkg;

    localparam int unsigned DATA_W_DEF = 32'd16;
    localparam int unsigned ADDR_W_DEF = 32'd8;
    localparam int unsigned BUS_W      = 32'd16;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RD_WAIT = 2'd1,
        ST_RD_DONE = 2'd2,
        ST_WR_DONE = 2'd3
    } state_t;

    // True when every bus-address bit above the implemented range is zero.
    function automatic logic addr_in_range(input logic [BUS_W-1:0] addr, input int unsigned aw);
        logic [BUS_W-1:0] hi_s;
        hi_s = addr >> aw;
        return (hi_s == 16'd0);
    endfunction

endpackage

// File: rtl/memory_responder_ram_array.sv
// Synchronous single-port data RAM: write and registered read share one address.
// Contents have no reset.
module memory_responder_ram_array #(
    parameter int unsigned DATA_W = 32'd16,
    parameter int unsigned ADDR_W = 32'd8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_r [0:(1 << ADDR_W)-1];

    // Storage write and registered read port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[addr] <= wdata;
        end else begin
            mem_r[addr] <= mem_r[addr];
        end
        rdata <= mem_r[addr];
    end

endmodule

// File: rtl/memory_responder.sv
// Memory-side responder: busy/done handshake around the data RAM with range checking.
// Optional write protection of low addresses is enabled by defining MEM_WRITE_PROTECT_EN.
module memory_responder
    import memory_responder_pkg::*;
#(
    parameter int unsigned DATA_W   = DATA_W_DEF,
    parameter int unsigned ADDR_W   = ADDR_W_DEF,
    parameter int unsigned RD_LAT   = 32'd2,
    parameter int unsigned WP_LIMIT = 32'd16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              read,
    input  logic              write,
    input  logic [BUS_W-1:0]  ram_addr,
    input  logic [DATA_W-1:0] ram_in,
    output logic [DATA_W-1:0] ram_out,
    output logic              busy,
    output logic              done,
    output logic              addr_err
);

`ifdef MEM_WRITE_PROTECT_EN
    localparam logic WP_ENABLE = 1'b1;
`else
    localparam logic WP_ENABLE = 1'b0;
`endif

    // The counter is loaded with RD_LAT-1 and the read leaves RD_WAIT when it reaches 1,
    // so done lands exactly RD_LAT edges after the accept edge.
    localparam logic [2:0] LAT_LOAD = 3'(RD_LAT - 32'd1);
    localparam state_t     RD_ENTRY = (RD_LAT == 32'd1) ? ST_RD_DONE : ST_RD_WAIT;

    state_t            state_r;
    logic [2:0]        cnt_r;
    logic [ADDR_W-1:0] addr_r;
    logic              err_r;
    logic              rd_zero_r;
    logic [DATA_W-1:0] ram_out_r;
    logic              busy_r;
    logic              done_r;
    logic              addr_err_r;

    logic              accept_s;
    logic              in_range_s;
    logic              protect_s;
    logic              we_s;
    logic [ADDR_W-1:0] ram_idx_s;
    logic [DATA_W-1:0] rdata_s;

    // Request qualification; the done cycle is held in IDLE without accepting.
    always_comb begin
        accept_s   = (state_r == ST_IDLE) && !done_r;
        in_range_s = addr_in_range(ram_addr, ADDR_W);
        protect_s  = WP_ENABLE && (ram_addr < 16'(WP_LIMIT));
        we_s       = accept_s && write && !read && in_range_s && !protect_s && !rst;
        ram_idx_s  = accept_s ? ram_addr[ADDR_W-1:0] : addr_r;
    end

    memory_responder_ram_array #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram_array (
        .clk   (clk),
        .we    (we_s),
        .addr  (ram_idx_s),
        .wdata (ram_in),
        .rdata (rdata_s)
    );

    // Request FSM with wait counter and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            cnt_r      <= 3'd0;
            addr_r     <= '0;
            err_r      <= 1'b0;
            rd_zero_r  <= 1'b0;
            ram_out_r  <= '0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            addr_err_r <= 1'b0;
        end else begin
            done_r     <= 1'b0;
            addr_err_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (accept_s && read) begin
                        addr_r    <= ram_addr[ADDR_W-1:0];
                        err_r     <= !in_range_s || write;
                        rd_zero_r <= !in_range_s;
                        cnt_r     <= LAT_LOAD;
                        busy_r    <= 1'b1;
                        state_r   <= RD_ENTRY;
                    end else if (accept_s && write) begin
                        err_r   <= !in_range_s || protect_s;
                        busy_r  <= 1'b1;
                        state_r <= ST_WR_DONE;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_RD_WAIT: begin
                    cnt_r <= cnt_r - 3'd1;
                    if (cnt_r <= 3'd1) begin
                        state_r <= ST_RD_DONE;
                    end else begin
                        state_r <= ST_RD_WAIT;
                    end
                end
                ST_RD_DONE: begin
                    ram_out_r  <= rd_zero_r ? '0 : rdata_s;
                    done_r     <= 1'b1;
                    addr_err_r <= err_r;
                    busy_r     <= 1'b0;
                    cnt_r      <= 3'd0;
                    state_r    <= ST_IDLE;
                end
                ST_WR_DONE: begin
                    done_r     <= 1'b1;
                    addr_err_r <= err_r;
                    busy_r     <= 1'b0;
                    state_r    <= ST_IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign ram_out  = ram_out_r;
    assign busy     = busy_r;
    assign done     = done_r;
    assign addr_err = addr_err_r;

endmodule
